// File: rtl/delay_meter.sv
// Launch/capture controller: toggles launch, counts cycles until sense follows, reports count/timeout.
// Optional DELAY_METER_AVG4_EN: four alternating-edge runs per start, count = truncated mean.
module delay_meter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sense,
  output logic             launch,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             sense_m, sense_s, ref_lvl;
  logic [CNT_W-1:0] cnt;

`ifdef DELAY_METER_AVG4_EN
  logic [1:0]       run;
  logic [CNT_W+1:0] sum, sum_nxt;
  assign sum_nxt = sum + (CNT_W+2)'(cnt);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sense_m <= 1'b0;
      sense_s <= 1'b0;
      ref_lvl <= 1'b0;
      cnt     <= '0;
      launch  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      count   <= '0;
`ifdef DELAY_METER_AVG4_EN
      run     <= '0;
      sum     <= '0;
`endif
    end else begin
      // synchroniser latency is deliberately part of the measured count
      sense_m <= sense;
      sense_s <= sense_m;
      done    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= ARM;
          busy    <= 1'b1;
          timeout <= 1'b0;
`ifdef DELAY_METER_AVG4_EN
          run     <= '0;
          sum     <= '0;
`endif
        end
        ARM: begin
          ref_lvl <= sense_s;
          launch  <= ~launch;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (sense_s != ref_lvl) begin
            state <= DONE;
`ifdef DELAY_METER_AVG4_EN
            if (run == 2'd3) begin
              count <= sum_nxt[CNT_W+1:2];
              done  <= 1'b1;
            end else begin
              sum <= sum_nxt;
              run <= run + 2'd1;
            end
`else
            count <= cnt;
            done  <= 1'b1;
`endif
          end else if (cnt == CNT_MAX) begin
            // timeout also aborts any remaining averaging runs
            count   <= CNT_MAX;
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
`ifdef DELAY_METER_AVG4_EN
          // done is only raised for the final (or aborted) run
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ARM;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/delay_meter.md
# delay_meter

Self-timed launch/capture stage for the delay-measurement design. On request it toggles a launch line into the external delay path under test (for example the ui_in→uo_out inverter path) and counts clock cycles until the returning edge arrives on its sense input. It is the measurement controller that drives and samples the delay path, and it reports a cycle count plus a timeout flag.

## Interface
- CNT_W, 8: result/counter width; timeout limit is 2^CNT_W−1.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  measurement request; synchronous to clk, sampled in IDLE only.
- sense  in  1  return from delay path; asynchronous, synchronised internally.
- launch  out  1  drive into delay path; registered.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse, result valid.
- timeout  out  1  last measurement hit the limit; held until next start accepted.
- count  out  CNT_W  last result; held until next done.

## Operation
- Sense path: 2-flop synchroniser (sense_s), reset to 0, included in the measured count.
- States: IDLE, ARM, WAIT, DONE.
- IDLE: start=1 → ARM; timeout cleared.
- ARM (one cycle): ref ← sense_s; launch ← ~launch; cnt ← 0; → WAIT.
- WAIT, each edge: if sense_s ≠ ref → count ← cnt, → DONE; else if cnt = 2^CNT_W−1 → count ← all-ones, timeout ← 1, → DONE; else cnt ← cnt+1.
- DONE (one cycle): done=1; → IDLE.
- launch is not restored after a measurement; successive measurements alternate rising/falling launch edges.
- start while busy ignored (no queueing).
- Counter saturates by construction, never wraps.

## Timing
- Reset values: launch=0, busy=0, done=0, timeout=0, count=0, state IDLE, sync flops 0, cnt 0.
- start sampled at edge S → ARM; launch toggles at edge E0 = S+1.
- Sense change arriving in (E_k, E_k+1] yields count = k+2; zero-delay loopback yields count = 2.
- done high in the cycle after the WAIT exit edge: for result c, done high during cycle after edge E0+c+1; busy falls at the following edge.
- Start-to-done latency: c+3 cycles after S.
- Timeout: WAIT exit after 2^CNT_W−1 increments; count=all-ones, timeout=1 together with done.
- rst mid-measurement: all outputs to reset values at that edge, no done pulse, launch returns to 0.
- start asserted in the DONE cycle is ignored; it is accepted from IDLE on the next cycle.

## Configuration
- DELAY_METER_AVG4_EN defined: each accepted start performs 4 back-to-back ARM/WAIT runs, with DONE→ARM directly between runs (ref re-captured, launch toggled each run, so 2 rising + 2 falling edges). Results accumulate in a CNT_W+2 sum. done pulses once after the fourth run with count = sum>>2 (truncating). Any run timing out aborts remaining runs: count=all-ones, timeout=1, done.
- Undefined: single measurement per start, as above.

## Test plan
- Loopback sense=launch, start pulse → launch 0→1 at E0, count=2, done one cycle, busy low afterwards; repeat → launch 1→0, count=2.
- Sense model delayed 5 cycles after launch edge → count=7, timeout=0.
- Sense tied 0, CNT_W=8 → done after 255 WAIT increments, count=0xFF, timeout=1; next start clears timeout.
- start held high continuously → measurements back-to-back, one done per measurement, no start accepted while busy.
- rst asserted two cycles into WAIT → launch=0, busy=0, count=0, no done; fresh start then measures normally.
- AVG4_EN, rise delay k=3, fall delay k=5 → run counts 5,7,5,7, sum 24, count=6, single done pulse.
